if_fetch_stage: RTL and testbench
=================================

Name: if_fetch_stage

Overview:
- Instruction-fetch stage directly upstream of the IF/ID pipeline register.
- Owns the PC and issues requests to instruction memory over a req/gnt/rvalid handshake, with at most one request outstanding.
- Each returned instruction and its address go into a one-entry fetch buffer that feeds IF/ID; when the buffer is empty, a NOP bubble is presented instead.
- Handles hazard-unit stalls and ID-stage redirects (branch/jump), including dropping a stale in-flight response.

Parameters:
- ADDR_WIDTH, 32, instruction address width.
- INST_WIDTH, 32, instruction width.
- RESET_PC, 32'h0000_0000, PC value after reset.
- NOP_INST, 32'h0000_0013, bubble instruction (addi x0,x0,0).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  from hazard unit; 1 = IF/ID not latching this cycle (same signal as IF_ID_Write).
- redirect_valid  in  1  from ID; taken branch or jump this cycle.
- redirect_target  in  ADDR_WIDTH  new PC when redirect_valid=1.
- imem_req  out  1  fetch request valid.
- imem_addr  out  ADDR_WIDTH  fetch address; always equals pc.
- imem_gnt  in  1  request accepted this cycle; only meaningful while imem_req=1.
- imem_rvalid  in  1  response valid; at most one per granted request, no earlier than the cycle after gnt.
- imem_rdata  in  INST_WIDTH  response instruction.
- inst_addr_out  out  ADDR_WIDTH  to IF/ID inst_addr_in.
- inst_out  out  INST_WIDTH  to IF/ID inst_in.
- inst_valid_out  out  1  1 = inst_out is a real fetched instruction.

Behaviour:
- Reset (async):
  - state=S_REQ, pc=RESET_PC, buf_valid=0, buf_inst=NOP_INST, buf_addr=RESET_PC.
  - Outputs during reset: imem_req=0, inst_out=NOP_INST, inst_addr_out=RESET_PC, inst_valid_out=0.
- Outputs are combinational from registers:
  - inst_out = buf_valid ? buf_inst : NOP_INST.
  - inst_addr_out = buf_addr.
  - inst_valid_out = buf_valid.
- Buffer consumption: on any clock edge with stall=0 and no redirect, buf_valid is cleared unless it is reloaded that same edge.
- FSM states: S_REQ, S_WAIT, S_DROP.
- S_REQ:
  - imem_req = !buf_valid || !stall. Never issue while a full buffer is stalled.
  - gnt with no redirect -> S_WAIT.
  - gnt with redirect in the same cycle -> pc<=redirect_target, go to S_DROP (the granted request was for the old pc).
  - redirect without gnt -> pc<=redirect_target, stay in S_REQ.
- S_WAIT:
  - rvalid with no redirect: buf_inst<=imem_rdata, buf_addr<=pc, buf_valid<=1, pc<=pc+4, -> S_REQ.
  - rvalid with redirect: discard rdata, pc<=redirect_target, -> S_REQ.
  - redirect without rvalid: pc<=redirect_target, -> S_DROP.
  - Neither: hold.
- S_DROP:
  - rvalid: discard, -> S_REQ.
  - redirect while in S_DROP: pc<=redirect_target, remain in S_DROP.
- A redirect in any state clears buf_valid that edge (wrong-path flush).
- Redirect has priority over stall in this block.
- Stall with a full buffer: buf_inst, buf_addr and buf_valid hold. No new request issues; an outstanding response is still accepted only if the buffer will be free. The hazard unit guarantees this cannot conflict, because the request is gated.
- PC arithmetic: pc+4 modulo 2^ADDR_WIDTH (wraps silently). redirect_target is used as-is, with no alignment check.
- Throughput: 1 instruction per 2 cycles with zero-wait memory (gnt in REQ, rvalid the next cycle).
- Reset mid-operation: all state is discarded. Instruction memory is reset by the same rst, so no stale rvalid follows reset.

Decomposition:
- Shared const package/header: ADDR/INST widths, NOP_INST, RESET_PC default, FSM state encodings (2-bit localparams S_REQ/S_WAIT/S_DROP).
- Optional sub-module: if_fetch_buffer (one-entry inst/addr/valid register with load/consume/flush).
- The FSM and PC stay in the top block.

Test Plan:
1. Reset: assert rst, release -> imem_req=1, imem_addr=0x0, inst_out=0x00000013, inst_valid_out=0.
2. Normal fetch: gnt in the first cycle, rvalid the next cycle with rdata=0x00500093 -> inst_out=0x00500093, inst_addr_out=0x0, inst_valid_out=1; next imem_addr=0x4.
3. Stall with a full buffer: hold stall=1 for 3 cycles after a fetch -> imem_req=0, inst_out stays 0x00500093. Release stall -> request to 0x4 issues.
4. Redirect in S_WAIT: target 0x100 while waiting -> the later rvalid (rdata 0xDEADBEEF) is dropped and never appears on inst_out; next imem_addr=0x100.
5. Redirect with a full buffer: redirect to 0x40 -> inst_valid_out=0 and inst_out=NOP next cycle; next request to 0x40.
6. Wrap: RESET_PC=0xFFFFFFFC, one fetch -> next imem_addr=0x00000000.

Source files
------------

// File: rtl/if_fetch_stage_pkg.sv
// Shared constants and FSM encoding for the instruction-fetch stage.
package if_fetch_stage_pkg;

    localparam int                    IF_ADDR_WIDTH = 32;
    localparam int                    IF_INST_WIDTH = 32;
    localparam logic [IF_ADDR_WIDTH-1:0] IF_RESET_PC = 32'h0000_0000;
    localparam logic [IF_INST_WIDTH-1:0] IF_NOP_INST = 32'h0000_0013;  // addi x0,x0,0

    // S_REQ : issuing a request for pc
    // S_WAIT: one request granted, waiting for its response
    // S_DROP: one request granted for a now-stale pc; its response is discarded
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/response handshake (req/gnt, then rvalid/rdata).
interface if_fetch_stage_if
    import if_fetch_stage_pkg::*;
#(
    parameter int AW = IF_ADDR_WIDTH,
    parameter int IW = IF_INST_WIDTH
);
    logic          req;
    logic [AW-1:0] addr;
    logic          gnt;
    logic          rvalid;
    logic [IW-1:0] rdata;

    // Fetch stage side
    modport master (
        output req,
        output addr,
        input  gnt,
        input  rvalid,
        input  rdata
    );

    // Instruction memory side
    modport slave (
        input  req,
        input  addr,
        output gnt,
        output rvalid,
        output rdata
    );
endinterface

// File: rtl/if_fetch_buffer.sv
// One-entry fetch buffer holding the instruction/address presented to IF/ID.
// Flush wins over load, load wins over consume; with none asserted it holds.
module if_fetch_buffer
    import if_fetch_stage_pkg::*;
#(
    parameter int                    ADDR_WIDTH = IF_ADDR_WIDTH,
    parameter int                    INST_WIDTH = IF_INST_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = IF_RESET_PC,
    parameter logic [INST_WIDTH-1:0] NOP_INST   = IF_NOP_INST
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  consume,
    input  logic                  flush,
    input  logic [INST_WIDTH-1:0] load_inst,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    output logic                  buf_valid,
    output logic [INST_WIDTH-1:0] buf_inst,
    output logic [ADDR_WIDTH-1:0] buf_addr
);

    logic                  valid_reg;
    logic [INST_WIDTH-1:0] inst_reg;
    logic [ADDR_WIDTH-1:0] addr_reg;

    // Buffer entry update: flush, reload, or drain when IF/ID latches it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_reg <= 1'b0;
            inst_reg  <= NOP_INST;
            addr_reg  <= RESET_PC;
        end else if (flush) begin
            valid_reg <= 1'b0;
        end else if (load) begin
            valid_reg <= 1'b1;
            inst_reg  <= load_inst;
            addr_reg  <= load_addr;
        end else if (consume) begin
            valid_reg <= 1'b0;
        end
    end

    assign buf_valid = valid_reg;
    assign buf_inst  = inst_reg;
    assign buf_addr  = addr_reg;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, runs the single-outstanding imem
// handshake, and feeds IF/ID through a one-entry buffer (NOP when empty).
module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter int                    ADDR_WIDTH = IF_ADDR_WIDTH,
    parameter int                    INST_WIDTH = IF_INST_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = IF_RESET_PC,
    parameter logic [INST_WIDTH-1:0] NOP_INST   = IF_NOP_INST
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_target,
    if_fetch_stage_if.master      imem,
    output logic [ADDR_WIDTH-1:0] inst_addr_out,
    output logic [INST_WIDTH-1:0] inst_out,
    output logic                  inst_valid_out
);

    fetch_state_e          state_reg;
    logic [ADDR_WIDTH-1:0] pc_reg;

    logic                  buf_valid;
    logic [INST_WIDTH-1:0] buf_inst;
    logic [ADDR_WIDTH-1:0] buf_addr;

    logic                  buf_free;
    logic                  granted;
    logic                  accept_rsp;

    // A stalled full buffer cannot take a new instruction this edge
    assign buf_free   = !(buf_valid && stall);
    assign granted    = imem.req && imem.gnt;
    // Only a response for the current pc, with no redirect, is kept
    assign accept_rsp = (state_reg == S_WAIT) && imem.rvalid && !redirect_valid && buf_free;

    // Requests are suppressed in reset and while a full buffer is stalled
    assign imem.req  = !rst && (state_reg == S_REQ) && (!buf_valid || !stall);
    assign imem.addr = pc_reg;

    // Fetch FSM and PC; a redirect always overrides the sequential pc
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_REQ;
            pc_reg    <= RESET_PC;
        end else begin
            case (state_reg)
                S_REQ: begin
                    if (redirect_valid) begin
                        pc_reg <= redirect_target;
                        // A grant this cycle was for the old pc: drop its response
                        if (granted) begin
                            state_reg <= S_DROP;
                        end
                    end else if (granted) begin
                        state_reg <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (redirect_valid) begin
                        pc_reg    <= redirect_target;
                        state_reg <= imem.rvalid ? S_REQ : S_DROP;
                    end else if (accept_rsp) begin
                        pc_reg    <= pc_reg + ADDR_WIDTH'(4);
                        state_reg <= S_REQ;
                    end
                end
                S_DROP: begin
                    if (redirect_valid) begin
                        pc_reg <= redirect_target;
                    end
                    if (imem.rvalid) begin
                        state_reg <= S_REQ;
                    end
                end
                default: state_reg <= S_REQ;
            endcase
        end
    end

    if_fetch_buffer #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .INST_WIDTH (INST_WIDTH),
        .RESET_PC   (RESET_PC),
        .NOP_INST   (NOP_INST)
    ) u_buffer (
        .clk       (clk),
        .rst       (rst),
        .load      (accept_rsp),
        .consume   (!stall),
        .flush     (redirect_valid),
        .load_inst (imem.rdata),
        .load_addr (pc_reg),
        .buf_valid (buf_valid),
        .buf_inst  (buf_inst),
        .buf_addr  (buf_addr)
    );

    assign inst_out       = buf_valid ? buf_inst : NOP_INST;
    assign inst_addr_out  = buf_addr;
    assign inst_valid_out = buf_valid;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: reset, fetch, stall, redirects, PC wrap.
module tb_if_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic [31:0] inst_addr_out, inst_out;
    logic        inst_valid_out;

    logic [31:0] inst_addr_out1, inst_out1;
    logic        inst_valid_out1;

    int total;
    int bad;

    if_fetch_stage_if #(.AW(32), .IW(32)) imem0 ();
    if_fetch_stage_if #(.AW(32), .IW(32)) imem1 ();

    if_fetch_stage dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .imem            (imem0),
        .inst_addr_out   (inst_addr_out),
        .inst_out        (inst_out),
        .inst_valid_out  (inst_valid_out)
    );

    if_fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk             (clk),
        .rst             (rst),
        .stall           (1'b0),
        .redirect_valid  (1'b0),
        .redirect_target (32'h0),
        .imem            (imem1),
        .inst_addr_out   (inst_addr_out1),
        .inst_out        (inst_out1),
        .inst_valid_out  (inst_valid_out1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("chk  %s got=%h exp=%h ok", tag, got, exp);
        end
    endtask

    // Advance to the next falling edge, away from the active edge
    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst = 1'b1;
        stall = 1'b0;
        redirect_valid = 1'b0;
        redirect_target = 32'h0;
        imem0.gnt = 1'b0; imem0.rvalid = 1'b0; imem0.rdata = 32'h0;
        imem1.gnt = 1'b0; imem1.rvalid = 1'b0; imem1.rdata = 32'h0;

        // Reset in progress
        tick(); tick();
        chk("rst_req",   {31'b0, imem0.req}, 32'd0);
        chk("rst_inst",  inst_out, NOP);
        chk("rst_addr",  inst_addr_out, 32'h0);
        chk("rst_valid", {31'b0, inst_valid_out}, 32'd0);

        // Reset released
        rst = 1'b0;
        #1;
        chk("post_req",   {31'b0, imem0.req}, 32'd1);
        chk("post_addr",  imem0.addr, 32'h0);
        chk("post_inst",  inst_out, NOP);
        chk("post_valid", {31'b0, inst_valid_out}, 32'd0);

        // Normal fetch: grant now, response next cycle
        imem0.gnt = 1'b1;
        tick();
        imem0.gnt = 1'b0; imem0.rvalid = 1'b1; imem0.rdata = 32'h0050_0093;
        #1;
        chk("wait_req", {31'b0, imem0.req}, 32'd0);
        tick();
        imem0.rvalid = 1'b0;
        stall = 1'b1;
        #1;
        chk("fetch_inst",  inst_out, 32'h0050_0093);
        chk("fetch_addr",  inst_addr_out, 32'h0);
        chk("fetch_valid", {31'b0, inst_valid_out}, 32'd1);
        chk("fetch_pc",    imem0.addr, 32'h4);
        chk("stall_req0",  {31'b0, imem0.req}, 32'd0);

        // Stall with full buffer held for three edges
        for (int i = 0; i < 3; i++) begin
            tick();
            #1;
            chk($sformatf("stall_req%0d", i + 1), {31'b0, imem0.req}, 32'd0);
            chk($sformatf("stall_inst%0d", i + 1), inst_out, 32'h0050_0093);
        end

        // Release stall: request to 0x4 issues, granted immediately
        stall = 1'b0;
        #1;
        chk("unstall_req",  {31'b0, imem0.req}, 32'd1);
        chk("unstall_addr", imem0.addr, 32'h4);
        imem0.gnt = 1'b1;
        tick();
        imem0.gnt = 1'b0;
        #1;
        chk("consumed_valid", {31'b0, inst_valid_out}, 32'd0);
        chk("consumed_inst",  inst_out, NOP);

        // Redirect while waiting: stale response must be dropped
        redirect_valid = 1'b1; redirect_target = 32'h100;
        tick();
        redirect_valid = 1'b0;
        imem0.rvalid = 1'b1; imem0.rdata = 32'hDEAD_BEEF;
        #1;
        chk("drop_req",  {31'b0, imem0.req}, 32'd0);
        chk("drop_addr", imem0.addr, 32'h100);
        tick();
        imem0.rvalid = 1'b0;
        #1;
        chk("drop_inst",  inst_out, NOP);
        chk("drop_valid", {31'b0, inst_valid_out}, 32'd0);
        chk("drop_req2",  {31'b0, imem0.req}, 32'd1);
        chk("drop_addr2", imem0.addr, 32'h100);

        // Fetch at 0x100
        imem0.gnt = 1'b1;
        tick();
        imem0.gnt = 1'b0; imem0.rvalid = 1'b1; imem0.rdata = 32'h00A0_0113;
        tick();
        imem0.rvalid = 1'b0;
        #1;
        chk("f100_inst", inst_out, 32'h00A0_0113);
        chk("f100_addr", inst_addr_out, 32'h100);
        chk("f100_pc",   imem0.addr, 32'h104);

        // Redirect with full buffer, while stalled: redirect wins and flushes
        stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h40;
        tick();
        stall = 1'b0; redirect_valid = 1'b0;
        #1;
        chk("flush_valid", {31'b0, inst_valid_out}, 32'd0);
        chk("flush_inst",  inst_out, NOP);
        chk("flush_pc",    imem0.addr, 32'h40);
        chk("flush_req",   {31'b0, imem0.req}, 32'd1);

        // Grant and redirect in the same cycle: granted request goes stale
        imem0.gnt = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h200;
        tick();
        imem0.gnt = 1'b0; redirect_valid = 1'b0;
        #1;
        chk("gr_req",  {31'b0, imem0.req}, 32'd0);
        chk("gr_addr", imem0.addr, 32'h200);
        imem0.rvalid = 1'b1; imem0.rdata = 32'h1111_1111;
        tick();
        imem0.rvalid = 1'b0;
        #1;
        chk("gr_req2",  {31'b0, imem0.req}, 32'd1);
        chk("gr_inst",  inst_out, NOP);
        chk("gr_valid", {31'b0, inst_valid_out}, 32'd0);

        // Response and redirect in the same cycle: response discarded
        imem0.gnt = 1'b1;
        tick();
        imem0.gnt = 1'b0;
        imem0.rvalid = 1'b1; imem0.rdata = 32'h2222_2222;
        redirect_valid = 1'b1; redirect_target = 32'h300;
        tick();
        imem0.rvalid = 1'b0; redirect_valid = 1'b0;
        #1;
        chk("rr_req",   {31'b0, imem0.req}, 32'd1);
        chk("rr_addr",  imem0.addr, 32'h300);
        chk("rr_valid", {31'b0, inst_valid_out}, 32'd0);
        chk("rr_inst",  inst_out, NOP);

        // PC wrap on the second instance
        chk("wrap_pc0", imem1.addr, 32'hFFFF_FFFC);
        imem1.gnt = 1'b1;
        tick();
        imem1.gnt = 1'b0; imem1.rvalid = 1'b1; imem1.rdata = 32'h0010_0073;
        tick();
        imem1.rvalid = 1'b0;
        #1;
        chk("wrap_pc1",  imem1.addr, 32'h0);
        chk("wrap_addr", inst_addr_out1, 32'hFFFF_FFFC);
        chk("wrap_inst", inst_out1, 32'h0010_0073);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
